freq_meter_mc: RTL
==================

# freq_meter_mc

Multi-channel gated frequency meter for the theremin audio path. It sits between the square-wave oscillator pins and the pitch/volume synthesis logic, replacing the single-input square-frequency conduit. Each of `NUM_CH` asynchronous square inputs has its rising edges counted over a common gate window. An offset set from the up/down buttons is subtracted from each count, and the results are streamed out one channel per beat over a valid/ready handshake.

## Interface
- `NUM_CH`, 2: number of square-wave inputs (1..8).
- `CNT_W`, 16: width of edge counters, offset and result (8..24).
- `GATE_CYCLES`, 50000: gate window length in `clk` cycles (≥ 2·NUM_CH+4).
- `STEP`, 16: offset change per button press.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous active-low reset (one clock; reset is asynchronous and active-low).
- `square_freq` in NUM_CH: asynchronous oscillator inputs.
- `freq_up_down` in 2: bit1 = up, bit0 = down; synchronous levels, acted on at rising edge.
- `meas_data` out CNT_W: corrected count for the current beat.
- `meas_ch` out 3: channel index of the current beat.
- `meas_valid` out 1: beat valid.
- `meas_ready` in 1: sink accepts beat.
- `overrun` out 1: sticky; a snapshot was dropped.
- `offset` out CNT_W: current offset register.

## Operation
- Per channel: a 2-flop synchroniser, then an edge register. A rising edge is a sync output of 1 while the previous value was 0.
- Gate counter counts 0..GATE_CYCLES-1 and wraps. The terminal cycle is `gate == GATE_CYCLES-1`.
- On the terminal cycle, the edge count of every channel (including an edge detected in that cycle) is copied to the snapshot. This happens only if the output FSM is IDLE. All edge counters then restart at 0.
- If the FSM is not IDLE on the terminal cycle:
  - the snapshot is not updated;
  - `overrun` is set and stays set until reset;
  - the counters still restart at 0.
- Offset register:
  - Rising edge of `freq_up_down[1]` adds `STEP`; rising edge of bit0 subtracts `STEP`.
  - The result saturates at 0 and at 2^CNT_W−1.
  - If both bits rise in the same cycle, nothing changes.
  - The offset is sampled at snapshot time.
- Result = snapshot − offset. If offset > snapshot, the result is 0.
- Output FSM states and transitions:
  - IDLE → SEND when a snapshot is taken; channel index is set to 0.
  - SEND holds `meas_valid` = 1.
  - On `meas_valid && meas_ready`: if the index is NUM_CH−1, go to IDLE; otherwise increment the index and stay in SEND.
- `meas_data` and `meas_ch` stay stable while `meas_valid` is high and `meas_ready` is low.

## Timing
- Reset values:
  - all counters, snapshot and `offset` = 0;
  - `meas_valid` = 0, `meas_data` = 0, `meas_ch` = 0;
  - `overrun` = 0;
  - FSM in IDLE;
  - synchroniser and edge registers = 0.
- Input edge to counter increment: 3 clk cycles.
- Terminal cycle to `meas_valid` high: 1 cycle.
- With `meas_ready` held high, the beats for ch0..chNUM_CH−1 appear on consecutive cycles. `meas_valid` falls the cycle after the last beat is accepted.
- Button edge to `offset` update: 1 cycle.
- Maximum countable input frequency is clk/2.
- Reset asserted mid-window or mid-stream: all state is cleared immediately. The gate restarts from 0 after `reset_n` deasserts.

## Configuration
- `FREQ_METER_SAT_EN` defined: each edge counter saturates at 2^CNT_W−1.
- `FREQ_METER_SAT_EN` undefined: each edge counter wraps modulo 2^CNT_W, with no flag.

## Test plan
- Channel decode: NUM_CH=2, GATE_CYCLES=1000, ch0 square with period 10 clk, ch1 with period 25 clk, ready=1 → beats (ch0, 100) then (ch1, 40) every window, ±1 count.
- Offset saturation:
  - 3 up pulses with STEP=16 → offset=48; ch0 reads 52.
  - 5 down pulses → offset=0.
  - Both bits rising together → offset unchanged.
- Backpressure: ready=0 for 20 cycles after valid → beat ch0 held stable; the next beats follow in order once ready=1.
- Overrun: ready=0 for more than GATE_CYCLES → `overrun`=1, old snapshot retained; the next window after draining reports fresh values.
- Counter limit: CNT_W=8, input period 2 clk, GATE_CYCLES=1000 → 255 with `FREQ_METER_SAT_EN`; 500 mod 256 = 244 without it.
- Reset: assert `reset_n`=0 mid-stream → `meas_valid`=0 and `offset`=0 immediately; the first post-reset snapshot arrives GATE_CYCLES+1 cycles after release.

Source files
------------

// File: rtl/freq_meter_mc.sv
// freq_meter_mc: multi-channel gated frequency meter.
// Counts rising edges of NUM_CH asynchronous square inputs over a common gate
// window, subtracts a button-controlled offset and streams one corrected count
// per channel over a valid/ready handshake.
// Optional build macro FREQ_METER_SAT_EN: edge counters saturate at all-ones
// instead of wrapping.
module freq_meter_mc #(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 16,
    parameter int GATE_CYCLES = 50000,
    parameter int STEP        = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] square_freq,
    input  logic [1:0]        freq_up_down,
    output logic [CNT_W-1:0]  meas_data,
    output logic [2:0]        meas_ch,
    output logic              meas_valid,
    input  logic              meas_ready,
    output logic              overrun,
    output logic [CNT_W-1:0]  offset
);

    localparam int               GATE_W    = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W:0]    STEP_X    = (CNT_W + 1)'(STEP);
    localparam logic [2:0]        CH_LAST   = 3'(NUM_CH - 1);

    typedef enum logic {IDLE, SEND} state_t;

    // Edge counter increment: wraps by default, optionally sticks at all-ones.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
`ifdef FREQ_METER_SAT_EN
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
`else
        return c + CNT_W'(1);
`endif
    endfunction

    // Offset step up, clamped at all-ones.
    function automatic logic [CNT_W-1:0] offset_add(input logic [CNT_W-1:0] o);
        logic [CNT_W:0] sum;
        sum = {1'b0, o} + STEP_X;
        return sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
    endfunction

    // Offset step down, clamped at zero.
    function automatic logic [CNT_W-1:0] offset_sub(input logic [CNT_W-1:0] o);
        logic signed [CNT_W+1:0] diff;
        diff = $signed({2'b00, o}) - $signed({1'b0, STEP_X});
        return (diff < 0) ? '0 : diff[CNT_W-1:0];
    endfunction

    // Corrected count: a - b, floored at zero.
    function automatic logic [CNT_W-1:0] floor_sub(input logic [CNT_W-1:0] a,
                                                   input logic [CNT_W-1:0] b);
        logic signed [CNT_W+1:0] diff;
        diff = $signed({2'b00, a}) - $signed({2'b00, b});
        return (diff < 0) ? '0 : diff[CNT_W-1:0];
    endfunction

    logic [NUM_CH-1:0] sync_p0, sync_p1, sync_p2;
    logic [NUM_CH-1:0] rise;
    logic [1:0]        btn_prev;
    logic              up_rise, dn_rise;
    logic [GATE_W-1:0] gate;
    logic              terminal;
    logic              take;
    logic [CNT_W-1:0]  count   [NUM_CH];
    logic [CNT_W-1:0]  cnt_cur [NUM_CH];
    logic [CNT_W-1:0]  snap    [NUM_CH];
    state_t            state, state_next;
    logic [2:0]        ch_idx, ch_idx_next;

    assign rise     = sync_p1 & ~sync_p2;
    assign up_rise  = freq_up_down[1] & ~btn_prev[1];
    assign dn_rise  = freq_up_down[0] & ~btn_prev[0];
    assign terminal = (gate == GATE_LAST);
    assign take     = terminal && (state == IDLE);
    assign meas_ch  = ch_idx;

    // Two-flop synchroniser plus previous-value register for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            sync_p2 <= '0;
        end else begin
            sync_p0 <= square_freq;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    // Gate window counter, 0..GATE_CYCLES-1 then wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gate <= '0;
        end else if (terminal) begin
            gate <= '0;
        end else begin
            gate <= gate + GATE_W'(1);
        end
    end

    // Count value including any edge seen in the current cycle.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_cur[i] = rise[i] ? cnt_inc(count[i]) : count[i];
        end
    end

    // Edge counters restart every window; snapshot only when the stream is idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                count[i] <= '0;
                snap[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                count[i] <= terminal ? '0 : cnt_cur[i];
                if (take) begin
                    snap[i] <= floor_sub(cnt_cur[i], offset);
                end
            end
        end
    end

    // Sticky flag: a window ended while the previous results were still streaming.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (terminal && (state != IDLE)) begin
            overrun <= 1'b1;
        end
    end

    // Offset register driven by button rising edges; simultaneous edges cancel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_prev <= '0;
            offset   <= '0;
        end else begin
            btn_prev <= freq_up_down;
            if (up_rise && !dn_rise) begin
                offset <= offset_add(offset);
            end else if (dn_rise && !up_rise) begin
                offset <= offset_sub(offset);
            end
        end
    end

    // Output FSM state and channel index registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            ch_idx <= '0;
        end else begin
            state  <= state_next;
            ch_idx <= ch_idx_next;
        end
    end

    // Output FSM next state and beat outputs.
    always_comb begin
        state_next  = state;
        ch_idx_next = ch_idx;
        meas_valid  = 1'b0;
        meas_data   = '0;
        case (state)
            IDLE: begin
                if (take) begin
                    state_next  = SEND;
                    ch_idx_next = '0;
                end
            end
            SEND: begin
                meas_valid = 1'b1;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (ch_idx == 3'(i)) begin
                        meas_data = snap[i];
                    end
                end
                if (meas_ready) begin
                    if (ch_idx == CH_LAST) begin
                        state_next  = IDLE;
                        ch_idx_next = '0;
                    end else begin
                        ch_idx_next = ch_idx + 3'd1;
                    end
                end
            end
            default: begin
                state_next  = IDLE;
                ch_idx_next = '0;
            end
        endcase
    end

endmodule
